// File: rtl/uart_tx_simple.sv
// uart_tx_simple: 8-bit UART transmitter. Each frame is a start bit, 8 data
// bits LSB-first, an optional parity bit, and 1 or 2 stop bits. A clock
// divider times every bit. All outputs come straight from flops.
module uart_tx_simple #(
  parameter int BAUD_RATE   = 115200,
  parameter int PARITY      = 0,
  parameter int STOP        = 1,
  parameter int CLK_FREQ_HZ = 33330000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       tx_start,
  output logic       serial_tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  // Unsupported PARITY codes fall back to no parity.
  localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_ODD = (PARITY == 1);
  // Unsupported STOP values fall back to one stop bit.
  localparam logic [2:0] STOP_LAST = (STOP == 2) ? 3'd1 : 3'd0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             serial_tx_q, serial_tx_d;
  logic             tx_busy_q, tx_busy_d;
  logic             tx_done_q, tx_done_d;
  logic             bit_end_s;

  assign bit_end_s = (clk_cnt_q == CNT_LAST);

  // Next-state and next-output logic. The line value is computed one cycle
  // ahead so that serial_tx can come straight from a flop.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    serial_tx_d = serial_tx_q;
    tx_busy_d   = tx_busy_q;
    tx_done_d   = 1'b0;

    if (state_q != S_IDLE) begin
      clk_cnt_d = bit_end_s ? {CNT_W{1'b0}} : (clk_cnt_q + CNT_W'(1));
    end else begin
      clk_cnt_d = {CNT_W{1'b0}};
    end

    case (state_q)
      S_IDLE: begin
        serial_tx_d = 1'b1;
        tx_busy_d   = 1'b0;
        if (tx_start) begin
          shift_d     = tx_byte;
          parity_d    = PAR_ODD ? ~^tx_byte : ^tx_byte;
          bit_cnt_d   = 3'd0;
          state_d     = S_START;
          serial_tx_d = 1'b0;
          tx_busy_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d     = S_DATA;
          serial_tx_d = shift_q[0];
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            if (PAR_EN) begin
              state_d     = S_PARITY;
              serial_tx_d = parity_q;
            end else begin
              state_d     = S_STOP;
              serial_tx_d = 1'b1;
            end
          end else begin
            bit_cnt_d   = bit_cnt_q + 3'd1;
            serial_tx_d = shift_q[1];
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (bit_end_s) begin
          state_d     = S_STOP;
          serial_tx_d = 1'b1;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        serial_tx_d = 1'b1;
        if (bit_end_s) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = 3'd0;
            state_d   = S_IDLE;
            tx_busy_d = 1'b0;
            tx_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d     = S_IDLE;
        serial_tx_d = 1'b1;
        tx_busy_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset forces the line idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      clk_cnt_q   <= {CNT_W{1'b0}};
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      parity_q    <= 1'b0;
      serial_tx_q <= 1'b1;
      tx_busy_q   <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      serial_tx_q <= serial_tx_d;
      tx_busy_q   <= tx_busy_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign serial_tx = serial_tx_q;
  assign tx_busy   = tx_busy_q;
  assign tx_done   = tx_done_q;

endmodule
